uart_ctrl: RTL
==============

UART_CTRL -- requirements
Module: uart_ctrl

Interface
REQ-001 SHALL have parameter WR_LOW_CYCLES, default 2: number of cycles uart_write_n is held low per byte.
REQ-002 SHALL have parameter RD_LOW_CYCLES, default 2: number of cycles uart_read_n is held low per byte.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 64: maximum cycles to wait for uart_txrdy to fall after a write strobe.
REQ-004 SHALL have port mclkx16  in  1: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have port req_valid  in  2: per-requester transmit request, bit n belongs to requester n.
REQ-007 SHALL have port req_data  in  16: transmit byte per requester; requester n uses bits [8n+7:8n].
REQ-008 SHALL have port req_ready  out  2: one-cycle accept pulse to the granted requester.
REQ-009 SHALL have port uart_datain  out  8: byte driven to the UART transmitter.
REQ-010 SHALL have port uart_write_n  out  1: active-low write strobe to the UART.
REQ-011 SHALL have port uart_txrdy  in  1: high means the UART transmitter is idle and can take a byte.
REQ-012 SHALL have port uart_read_n  out  1: active-low read strobe to the UART.
REQ-013 SHALL have port uart_rxrdy  in  1: high means a received byte is pending in the UART.
REQ-014 SHALL have port uart_dataout  in  8: received byte from the UART.
REQ-015 SHALL have port uart_err  in  3: UART receive flags {overrun, framingerr, parityerr}.
REQ-016 SHALL have port rx_valid  out  1: rx_data/rx_err hold an unconsumed byte.
REQ-017 SHALL have port rx_data  out  8: captured received byte.
REQ-018 SHALL have port rx_err  out  3: captured uart_err sampled with rx_data.
REQ-019 SHALL have port rx_ready  in  1: consumer accepts the byte when rx_valid&rx_ready.
REQ-020 SHALL have port status  out  3: sticky flags {tx_timeout, rx_drop, reserved=0}.

Function
REQ-021 TX FSM SHALL use states T_IDLE, T_WRITE, T_WAIT_ACK, T_WAIT_DONE.
REQ-022 In T_IDLE, with uart_txrdy=1 and any req_valid bit set, SHALL grant: pulse the winner's req_ready, latch its byte into uart_datain, go to T_WRITE.
REQ-023 Arbitration SHALL be round-robin: if both bits are set, grant the requester not granted last; the pointer resets to favour requester 0.
REQ-024 T_WRITE SHALL hold uart_write_n=0 for exactly WR_LOW_CYCLES cycles, then release it to 1 and enter T_WAIT_ACK.
REQ-025 T_WAIT_ACK SHALL go to T_WAIT_DONE when uart_txrdy=0; after ACK_TIMEOUT cycles without that, it SHALL set status[2] and return to T_IDLE.
REQ-026 T_WAIT_DONE SHALL return to T_IDLE when uart_txrdy=1; uart_datain SHALL stay stable from grant until T_IDLE.
REQ-027 No grant SHALL occur in the T_IDLE cycle entered from T_WAIT_DONE; grant-to-next-strobe spacing is at least 1 idle cycle.
REQ-028 RX FSM SHALL use states R_IDLE, R_READ, R_WAIT_CLR.
REQ-029 In R_IDLE, uart_rxrdy=1 SHALL enter R_READ; R_READ SHALL hold uart_read_n=0 for RD_LOW_CYCLES cycles.
REQ-030 Capture SHALL occur on the last low cycle: uart_dataout to rx_data, uart_err to rx_err, rx_valid set; then enter R_WAIT_CLR.
REQ-031 If at capture rx_valid=1 and rx_ready=0, SHALL discard the new byte, keep the old buffer, and set status[1].
REQ-032 If rx_valid=1 and rx_ready=1 in the capture cycle, SHALL load the new byte and keep rx_valid=1.
REQ-033 rx_valid&rx_ready with no capture SHALL clear rx_valid next cycle.
REQ-034 R_WAIT_CLR SHALL return to R_IDLE only when uart_rxrdy=0, so no byte is read twice.
REQ-035 TX and RX FSMs SHALL run concurrently and independently.
REQ-036 Status flags SHALL clear only on reset.

Reset
REQ-037 On reset SHALL set: FSMs to T_IDLE/R_IDLE, uart_write_n=1, uart_read_n=1, req_ready=0, uart_datain=0, rx_valid=0, rx_data=0, rx_err=0, status=0, RR pointer favouring requester 0.
REQ-038 Reset mid-strobe SHALL release the strobe to 1 on the next edge and abandon the byte.

Structure
REQ-039 A shared package uart_pkg SHALL hold the tx_state_t and rx_state_t enums and the status bit index constants.
REQ-040 The round-robin arbiter SHALL be one sub-module, uart_rr_arb2.

Verification
REQ-041 req_valid=01, byte 0x55, txrdy=1 -> req_ready=01 for 1 cycle, uart_datain=0x55, write_n low for 2 cycles.
REQ-042 Both requesters held valid (0xA0, 0xA1) for 4 bytes -> order A0,A1,A0,A1.
REQ-043 After a strobe, txrdy held 1 for 64 cycles -> status[2]=1, FSM idle, next request granted.
REQ-044 rxrdy pulse with dataout=0x3C, err=3'b010 -> read_n low for 2 cycles, rx_data=0x3C, rx_err=010, rx_valid=1.
REQ-045 Second byte 0x7E arrives with rx_ready=0 -> rx_data stays 0x3C, status[1]=1.
REQ-046 Loopback of UART tx to rx, bytes 0x00..0x86 -> every rx_data equals the sent byte, rx_err=000.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART host-side controller: FSM state encodings and status bit positions.
// No logic or latency of its own; it is consumed by uart_ctrl and uart_rr_arb2.
package uart_pkg;

    typedef enum logic [1:0] {
        T_IDLE      = 2'd0,
        T_WRITE     = 2'd1,
        T_WAIT_ACK  = 2'd2,
        T_WAIT_DONE = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        R_IDLE     = 2'd0,
        R_READ     = 2'd1,
        R_WAIT_CLR = 2'd2
    } rx_state_t;

    localparam int ST_TX_TIMEOUT = 2;
    localparam int ST_RX_DROP    = 1;
    localparam int ST_RSVD       = 0;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin arbiter: the grant is combinational from req, and priority moves past the winner on take.
// There is no backpressure; the caller asserts take only in a cycle where it actually consumes the grant.
module uart_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       take,
    output logic [1:0] gnt
);

    // prio=1 means requester 1 wins a tie.
    logic prio;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = prio ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (take && (gnt != 2'b00)) begin
            prio <= gnt[0];
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// Bridges two transmit requesters and one receive consumer onto a UART host bus (datain/write_n, dataout/read_n).
// A grant pulses req_ready in the idle cycle; the TX side stalls on uart_txrdy, and a full RX buffer drops new bytes.
module uart_ctrl
    import uart_pkg::*;
#(
    parameter int WR_LOW_CYCLES = 2,
    parameter int RD_LOW_CYCLES = 2,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic        mclkx16,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    input  logic [15:0] req_data,
    output logic [1:0]  req_ready,
    output logic [7:0]  uart_datain,
    output logic        uart_write_n,
    input  logic        uart_txrdy,
    output logic        uart_read_n,
    input  logic        uart_rxrdy,
    input  logic [7:0]  uart_dataout,
    input  logic [2:0]  uart_err,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic [2:0]  rx_err,
    input  logic        rx_ready,
    output logic [2:0]  status
);

    localparam int TX_CW = $clog2(max2(WR_LOW_CYCLES, ACK_TIMEOUT) + 1);
    localparam int RX_CW = $clog2(RD_LOW_CYCLES + 1);
    localparam logic [TX_CW-1:0] WR_LAST  = TX_CW'(WR_LOW_CYCLES - 1);
    localparam logic [TX_CW-1:0] ACK_LAST = TX_CW'(ACK_TIMEOUT - 1);
    localparam logic [RX_CW-1:0] RD_LAST  = RX_CW'(RD_LOW_CYCLES - 1);

    tx_state_t        tx_state, tx_next;
    logic [TX_CW-1:0] tx_cnt;
    logic             idle_hold;
    logic             tx_grant;
    logic             tx_timeout;
    logic [1:0]       arb_gnt;

    rx_state_t        rx_state, rx_next;
    logic [RX_CW-1:0] rx_cnt;
    logic             rx_capture;
    logic             rx_drop;

    logic             st_tx_timeout;
    logic             st_rx_drop;

    uart_rr_arb2 u_arb (
        .clk   (mclkx16),
        .reset (reset),
        .req   (req_valid),
        .take  (tx_grant),
        .gnt   (arb_gnt)
    );

    // idle_hold blocks a grant in the first idle cycle after a completed byte.
    assign tx_grant   = (tx_state == T_IDLE) && !reset && uart_txrdy && !idle_hold && (req_valid != 2'b00);
    assign tx_timeout = (tx_state == T_WAIT_ACK) && uart_txrdy && (tx_cnt == ACK_LAST);

    always_ff @(posedge mclkx16) begin
        if (reset) begin
            tx_state <= T_IDLE;
        end else begin
            tx_state <= tx_next;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE: begin
                if (tx_grant) tx_next = T_WRITE;
            end
            T_WRITE: begin
                if (tx_cnt == WR_LAST) tx_next = T_WAIT_ACK;
            end
            T_WAIT_ACK: begin
                if (!uart_txrdy) begin
                    tx_next = T_WAIT_DONE;
                end else if (tx_cnt == ACK_LAST) begin
                    tx_next = T_IDLE;
                end
            end
            T_WAIT_DONE: begin
                if (uart_txrdy) tx_next = T_IDLE;
            end
            default: tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = tx_grant ? arb_gnt : 2'b00;
        uart_write_n = (tx_state != T_WRITE);
    end

    always_ff @(posedge mclkx16) begin
        if (reset) begin
            tx_cnt      <= '0;
            uart_datain <= 8'h00;
            idle_hold   <= 1'b0;
        end else begin
            idle_hold <= (tx_state == T_WAIT_DONE) && uart_txrdy;
            if (tx_state != tx_next) begin
                tx_cnt <= '0;
            end else if ((tx_state == T_WRITE) || (tx_state == T_WAIT_ACK)) begin
                tx_cnt <= tx_cnt + TX_CW'(1);
            end
            if (tx_grant) begin
                uart_datain <= arb_gnt[1] ? req_data[15:8] : req_data[7:0];
            end
        end
    end

    assign rx_capture = (rx_state == R_READ) && (rx_cnt == RD_LAST);
    assign rx_drop    = rx_capture && rx_valid && !rx_ready;

    always_ff @(posedge mclkx16) begin
        if (reset) begin
            rx_state <= R_IDLE;
        end else begin
            rx_state <= rx_next;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE: begin
                if (uart_rxrdy) rx_next = R_READ;
            end
            R_READ: begin
                if (rx_capture) rx_next = R_WAIT_CLR;
            end
            R_WAIT_CLR: begin
                // Wait for the UART to drop rxrdy so the same byte is never read twice.
                if (!uart_rxrdy) rx_next = R_IDLE;
            end
            default: rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        uart_read_n = (rx_state != R_READ);
    end

    always_ff @(posedge mclkx16) begin
        if (reset) begin
            rx_cnt   <= '0;
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
            rx_err   <= 3'b000;
        end else begin
            rx_cnt <= (rx_state == R_READ) ? rx_cnt + RX_CW'(1) : '0;
            if (rx_capture && !rx_drop) begin
                rx_valid <= 1'b1;
                rx_data  <= uart_dataout;
                rx_err   <= uart_err;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge mclkx16) begin
        if (reset) begin
            st_tx_timeout <= 1'b0;
            st_rx_drop    <= 1'b0;
        end else begin
            if (tx_timeout) st_tx_timeout <= 1'b1;
            if (rx_drop)    st_rx_drop    <= 1'b1;
        end
    end

    always_comb begin
        status                = 3'b000;
        status[ST_TX_TIMEOUT] = st_tx_timeout;
        status[ST_RX_DROP]    = st_rx_drop;
        status[ST_RSVD]       = 1'b0;
    end

endmodule
